// File: rtl/iopmp_entry_walker.sv
// Sequential IOPMP checker: walks one entry per cycle in priority order and
// keeps a sticky record of the first denied request until software clears it.
module iopmp_entry_walker #(
    parameter int PLEN              = 34,
    parameter int NR_ENTRIES        = 32,
    parameter int NR_ENTRIES_PER_MD = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic [NR_ENTRIES*(PLEN-2)-1:0] entry_addr_i,
    input  logic [NR_ENTRIES*8-1:0]        entry_cfg_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [PLEN-1:0]                req_addr_i,
    input  logic [2:0]                     req_access_i,
    input  logic [13:0]                    req_sid_i,
    input  logic [62:0]                    req_md_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_allow_o,
    output logic                           rsp_matched_o,
    output logic [4:0]                     rsp_entry_o,
    output logic                           rsp_irq_o,
    output logic                           err_valid_o,
    output logic                           err_ovf_o,
    output logic [31:0]                    err_rcd_o,
    output logic [PLEN-1:0]                err_addr_o,
    input  logic                           err_clear_i
);

    localparam int AW    = PLEN - 2;
    localparam int NR_MD = NR_ENTRIES / NR_ENTRIES_PER_MD;

    localparam logic [62:0] MD_MASK  = 63'((64'd1 << NR_MD) - 64'd1);
    localparam logic [4:0]  LAST_IDX = 5'(NR_ENTRIES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_TOR   = 2'd1;
    localparam logic [1:0] MODE_NA4   = 2'd2;
    localparam logic [1:0] MODE_NAPOT = 2'd3;

    localparam logic [2:0] ACC_READ  = 3'b001;
    localparam logic [2:0] ACC_WRITE = 3'b010;

    logic [1:0]      state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [PLEN-1:0] addr_q, addr_d;
    logic [2:0]      access_q, access_d;
    logic [13:0]     sid_q, sid_d;
    logic [62:0]     md_q, md_d;
    logic            allow_q, allow_d;
    logic            matched_q, matched_d;
    logic [4:0]      entry_q, entry_d;
    logic            irq_q, irq_d;
    logic            err_valid_q, err_valid_d;
    logic            err_ovf_q, err_ovf_d;
    logic [31:0]     err_rcd_q, err_rcd_d;
    logic [PLEN-1:0] err_addr_q, err_addr_d;

    // Entry tables padded to 32 so a 5-bit index never falls outside the array.
    logic [AW-1:0] ent_addr [32];
    logic [7:0]    ent_cfg  [32];

    for (genvar g = 0; g < 32; g++) begin : g_ent
        if (g < NR_ENTRIES) begin : g_impl
            assign ent_addr[g] = entry_addr_i[g*AW +: AW];
            assign ent_cfg[g]  = entry_cfg_i[g*8 +: 8];
        end else begin : g_none
            assign ent_addr[g] = '0;
            assign ent_cfg[g]  = '0;
        end
    end

    logic [AW-1:0] word;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] napot_keep;
    logic [7:0]    cur_cfg;
    logic [5:0]    md_sel;
    logic          eligible;
    logic          hit;
    logic          match;
    logic          perm;
    logic          illcgt;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        word      = addr_q[PLEN-1:2];
        cur_addr  = ent_addr[idx_q];
        cur_cfg   = ent_cfg[idx_q];
        prev_addr = '0;
        if (idx_q != 5'd0) begin
            prev_addr = ent_addr[idx_q - 5'd1];
        end
        // NAPOT keeps only the bits above the first zero counted from the LSB.
        napot_keep = ~(cur_addr ^ (cur_addr + AW'(1)));
        md_sel     = 6'(32'(idx_q) / NR_ENTRIES_PER_MD);
        eligible   = md_q[md_sel] && (cur_cfg[4:3] != MODE_OFF);

        hit = 1'b0;
        case (cur_cfg[4:3])
            MODE_TOR:   hit = (prev_addr <= word) && (word < cur_addr);
            MODE_NA4:   hit = (word == cur_addr);
            MODE_NAPOT: hit = ((word & napot_keep) == (cur_addr & napot_keep));
            default:    hit = 1'b0;
        endcase

        match  = eligible && hit;
        perm   = ((access_q == ACC_READ) && cur_cfg[0]) || ((access_q == ACC_WRITE) && cur_cfg[1]);
        illcgt = ((md_q & MD_MASK) == 63'd0);
    end

    logic deny;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        access_d  = access_q;
        sid_d     = sid_q;
        md_d      = md_q;
        allow_d   = allow_q;
        matched_d = matched_q;
        entry_d   = entry_q;
        irq_d     = irq_q;
        deny      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    access_d = req_access_i;
                    sid_d    = req_sid_i;
                    md_d     = req_md_i;
                    idx_d    = 5'd0;
                    if (enable_i) begin
                        state_d = ST_WALK;
                    end else begin
                        state_d   = ST_RESP;
                        allow_d   = 1'b1;
                        matched_d = 1'b0;
                        entry_d   = 5'd0;
                        irq_d     = 1'b0;
                    end
                end
            end
            ST_WALK: begin
                if (match) begin
                    state_d   = ST_RESP;
                    allow_d   = perm;
                    matched_d = 1'b1;
                    entry_d   = idx_q;
                    irq_d     = ~perm & cur_cfg[2];
                    deny      = ~perm;
                end else if (idx_q == LAST_IDX) begin
                    state_d   = ST_RESP;
                    allow_d   = 1'b0;
                    matched_d = 1'b0;
                    entry_d   = 5'd0;
                    irq_d     = 1'b0;
                    deny      = 1'b1;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear acts first so a deny in the same cycle starts a fresh record.
    always_comb begin
        err_valid_d = err_valid_q & ~err_clear_i;
        err_ovf_d   = err_ovf_q & ~err_clear_i;
        err_rcd_d   = err_rcd_q;
        err_addr_d  = err_addr_q;
        if (deny) begin
            if (!err_valid_d) begin
                err_valid_d = 1'b1;
                err_rcd_d   = {illcgt, 3'b000, 13'd0, (access_q == ACC_READ), sid_q};
                err_addr_d  = addr_q;
            end else begin
                err_ovf_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            addr_q      <= '0;
            access_q    <= 3'd0;
            sid_q       <= 14'd0;
            md_q        <= 63'd0;
            allow_q     <= 1'b0;
            matched_q   <= 1'b0;
            entry_q     <= 5'd0;
            irq_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_rcd_q   <= 32'd0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            access_q    <= access_d;
            sid_q       <= sid_d;
            md_q        <= md_d;
            allow_q     <= allow_d;
            matched_q   <= matched_d;
            entry_q     <= entry_d;
            irq_q       <= irq_d;
            err_valid_q <= err_valid_d;
            err_ovf_q   <= err_ovf_d;
            err_rcd_q   <= err_rcd_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_allow_o   = allow_q;
    assign rsp_matched_o = matched_q;
    assign rsp_entry_o   = entry_q;
    assign rsp_irq_o     = irq_q;
    assign err_valid_o   = err_valid_q;
    assign err_ovf_o     = err_ovf_q;
    assign err_rcd_o     = err_rcd_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_iopmp_entry_walker.sv
// Bench for iopmp_entry_walker: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_iopmp_entry_walker;

    localparam int PLEN   = 34;
    localparam int NR     = 32;
    localparam int PER_MD = 8;
    localparam int AW     = PLEN - 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              enable_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [PLEN-1:0]   req_addr_i = '0;
    logic [2:0]        req_access_i = 3'd0;
    logic [13:0]       req_sid_i = 14'd0;
    logic [62:0]       req_md_i = 63'd0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic              rsp_allow_o;
    logic              rsp_matched_o;
    logic [4:0]        rsp_entry_o;
    logic              rsp_irq_o;
    logic              err_valid_o;
    logic              err_ovf_o;
    logic [31:0]       err_rcd_o;
    logic [PLEN-1:0]   err_addr_o;
    logic              err_clear_i = 1'b0;

    logic [AW-1:0]     ent_addr [NR];
    logic [7:0]        ent_cfg  [NR];
    logic [NR*AW-1:0]  entry_addr_flat;
    logic [NR*8-1:0]   entry_cfg_flat;

    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        entry_addr_flat = '0;
        entry_cfg_flat  = '0;
        for (int i = 0; i < NR; i++) begin
            entry_addr_flat[i*AW +: AW] = ent_addr[i];
            entry_cfg_flat[i*8 +: 8]    = ent_cfg[i];
        end
    end

    iopmp_entry_walker #(
        .PLEN              (PLEN),
        .NR_ENTRIES        (NR),
        .NR_ENTRIES_PER_MD (PER_MD)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .entry_addr_i  (entry_addr_flat),
        .entry_cfg_i   (entry_cfg_flat),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_access_i  (req_access_i),
        .req_sid_i     (req_sid_i),
        .req_md_i      (req_md_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_allow_o   (rsp_allow_o),
        .rsp_matched_o (rsp_matched_o),
        .rsp_entry_o   (rsp_entry_o),
        .rsp_irq_o     (rsp_irq_o),
        .err_valid_o   (err_valid_o),
        .err_ovf_o     (err_ovf_o),
        .err_rcd_o     (err_rcd_o),
        .err_addr_o    (err_addr_o),
        .err_clear_i   (err_clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic       allow;
        logic       matched;
        logic [4:0] entry;
        logic       irq;
    } res_t;

    typedef enum int { M_IDLE, M_BUSY, M_RESP } mphase_t;

    mphase_t         m_phase = M_IDLE;
    int              m_left  = 0;
    res_t            m_res   = '0;
    logic [PLEN-1:0] m_addr  = '0;
    logic [2:0]      m_acc   = 3'd0;
    logic [13:0]     m_sid   = 14'd0;
    logic [62:0]     m_md    = 63'd0;
    logic            m_ev    = 1'b0;
    logic            m_ovf   = 1'b0;
    logic [31:0]     m_rcd   = 32'd0;
    logic [PLEN-1:0] m_eaddr = '0;

    // Scans the table in priority order using address ranges; edges = clock edges
    // after acceptance until the response appears.
    function automatic res_t decide(input logic [PLEN-1:0] addr, input logic [2:0] acc,
                                    input logic [62:0] md, output int edges);
        res_t            r;
        longint unsigned a, e, lo, size, base;
        int              t;
        bit              hit;
        logic [1:0]      mode;
        a     = 64'(addr) >> 2;
        r     = '0;
        edges = NR;
        for (int i = 0; i < NR; i++) begin
            mode = ent_cfg[i][4:3];
            e    = 64'(ent_addr[i]);
            hit  = 1'b0;
            if (md[i / PER_MD] && mode != 2'd0) begin
                case (mode)
                    2'd1: begin
                        lo = 64'd0;
                        if (i > 0) lo = 64'(ent_addr[i-1]);
                        hit = (a >= lo) && (a < e);
                    end
                    2'd2: hit = (a == e);
                    default: begin
                        t = 0;
                        while (t < AW && e[t]) t++;
                        size = 64'd1 << (t + 1);
                        base = e - (e % size);
                        hit  = (a >= base) && (a < base + size);
                    end
                endcase
            end
            if (hit) begin
                r.matched = 1'b1;
                r.entry   = 5'(i);
                r.allow   = (acc == 3'b001 && ent_cfg[i][0]) || (acc == 3'b010 && ent_cfg[i][1]);
                r.irq     = !r.allow && ent_cfg[i][2];
                edges     = i + 1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        bit deny;
        bit illcgt;
        int edges;
        deny = 1'b0;
        if (!rst_ni) begin
            m_phase = M_IDLE;
            m_ev    = 1'b0;
            m_ovf   = 1'b0;
            m_rcd   = 32'd0;
            m_eaddr = '0;
            return;
        end
        case (m_phase)
            M_IDLE: begin
                if (req_valid_i) begin
                    m_addr = req_addr_i;
                    m_acc  = req_access_i;
                    m_sid  = req_sid_i;
                    m_md   = req_md_i;
                    if (enable_i) begin
                        m_res   = decide(req_addr_i, req_access_i, req_md_i, edges);
                        m_left  = edges;
                        m_phase = M_BUSY;
                    end else begin
                        m_res   = '{allow: 1'b1, matched: 1'b0, entry: 5'd0, irq: 1'b0};
                        m_phase = M_RESP;
                    end
                end
            end
            M_BUSY: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = M_RESP;
                    deny    = !m_res.allow;
                end
            end
            M_RESP: if (rsp_ready_i) m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
        if (err_clear_i) begin
            m_ev  = 1'b0;
            m_ovf = 1'b0;
        end
        if (deny) begin
            if (!m_ev) begin
                illcgt  = ((64'(m_md) % (64'd1 << (NR / PER_MD))) == 64'd0);
                m_ev    = 1'b1;
                m_rcd   = (32'(illcgt) << 31) + (32'(m_acc == 3'b001) << 14) + 32'(m_sid);
                m_eaddr = m_addr;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        model_step();
    end

    // Cycle compare: one time unit after each rising edge.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (!rst_ni) begin
            check("rst_req_ready", req_ready_o, 1'b1);
            check("rst_rsp_valid", rsp_valid_o, 1'b0);
            check("rst_rsp_fields", {rsp_allow_o, rsp_matched_o, rsp_entry_o, rsp_irq_o}, 8'd0);
            check("rst_err_flags", {err_valid_o, err_ovf_o}, 2'd0);
            check("rst_err_rcd", err_rcd_o, 32'd0);
            check("rst_err_addr", err_addr_o, '0);
        end else begin
            check("req_ready", req_ready_o, m_phase == M_IDLE);
            check("rsp_valid", rsp_valid_o, m_phase == M_RESP);
            if (m_phase == M_RESP) begin
                check("rsp_allow", rsp_allow_o, m_res.allow);
                check("rsp_matched", rsp_matched_o, m_res.matched);
                check("rsp_entry", rsp_entry_o, m_res.entry);
                check("rsp_irq", rsp_irq_o, m_res.irq);
            end
            check("err_valid", err_valid_o, m_ev);
            check("err_ovf", err_ovf_o, m_ovf);
            if (m_ev) begin
                check("err_rcd", err_rcd_o, m_rcd);
                check("err_addr", err_addr_o, m_eaddr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_entries();
        for (int i = 0; i < NR; i++) begin
            ent_addr[i] = '0;
            ent_cfg[i]  = 8'd0;
        end
    endtask

    task automatic random_entries();
        int t;
        for (int i = 0; i < NR; i++) begin
            logic [1:0] mode;
            mode = 2'($urandom_range(0, 3));
            if (mode == 2'd3) begin
                t = $urandom_range(0, 4);
                ent_addr[i] = AW'(($urandom_range(0, 127) & ~((1 << (t + 1)) - 1)) | ((1 << t) - 1));
            end else begin
                ent_addr[i] = AW'($urandom_range(0, 127));
            end
            ent_cfg[i] = {3'($urandom), mode, 3'($urandom)};
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk_i);
        err_clear_i = 1'b1;
        @(negedge clk_i);
        err_clear_i = 1'b0;
    endtask

    // Issues one request, measures the response cycle (1 = cycle starting at the
    // acceptance edge), optionally pulses err_clear so it lands on edge clr_cyc,
    // holds rsp_ready low for 'hold' cycles, then completes the handshake.
    task automatic do_req(input logic en, input logic [PLEN-1:0] addr, input logic [2:0] acc,
                          input logic [13:0] sid, input logic [62:0] md, input int clr_cyc,
                          input int hold, output int cyc, output res_t got_res);
        bit got;
        @(negedge clk_i);
        check("req_ready_idle", req_ready_o, 1'b1);
        enable_i     = en;
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_access_i = acc;
        req_sid_i    = sid;
        req_md_i     = md;
        @(posedge clk_i);
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clk_i);
            cyc++;
            req_valid_i = 1'b0;
            enable_i    = 1'($urandom);
            if (rsp_valid_o) got = 1'b1;
            else err_clear_i = (cyc + 1 == clr_cyc);
        end
        err_clear_i = 1'b0;
        check("rsp_arrived", got, 1'b1);
        got_res = '{allow: rsp_allow_o, matched: rsp_matched_o, entry: rsp_entry_o, irq: rsp_irq_o};
        repeat (hold) @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        res_t r;
        bit   saw_rsp;

        clear_entries();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Bypass
        do_req(1'b0, 34'h1000, 3'b001, 14'd1, 63'd0, 0, 1, cyc, r);
        check("bypass_cycle", cyc, 1);
        check("bypass_allow", r.allow, 1'b1);
        check("bypass_matched", r.matched, 1'b0);

        // NA4 hit on entry 3
        ent_addr[3] = AW'(32'h400);
        ent_cfg[3]  = 8'h11;
        do_req(1'b1, 34'h1000, 3'b001, 14'd2, 63'd1, 0, 2, cyc, r);
        check("na4_cycle", cyc, 5);
        check("na4_allow", r.allow, 1'b1);
        check("na4_entry", r.entry, 5'd3);

        // Priority and MD masking
        clear_entries();
        ent_addr[1] = AW'(32'h800);
        ent_cfg[1]  = 8'h0C;
        ent_addr[9] = AW'(32'h4FF);
        ent_cfg[9]  = 8'h19;
        do_req(1'b1, 34'h1000, 3'b001, 14'd3, 63'b10, 0, 0, cyc, r);
        check("md_skip_cycle", cyc, 11);
        check("md_skip_allow", r.allow, 1'b1);
        check("md_skip_entry", r.entry, 5'd9);
        do_req(1'b1, 34'h1000, 3'b001, 14'd3, 63'b11, 0, 0, cyc, r);
        check("prio_cycle", cyc, 3);
        check("prio_allow", r.allow, 1'b0);
        check("prio_entry", r.entry, 5'd1);
        check("prio_irq", r.irq, 1'b1);

        // No match with all entries off
        pulse_clear();
        clear_entries();
        do_req(1'b1, 34'h2000, 3'b010, 14'd5, 63'd1, 0, 0, cyc, r);
        check("nomatch_cycle", cyc, 33);
        check("nomatch_allow", r.allow, 1'b0);
        check("nomatch_matched", r.matched, 1'b0);
        check("nomatch_err_valid", err_valid_o, 1'b1);
        check("nomatch_err_rcd", err_rcd_o, 32'h0000_0005);
        check("nomatch_err_addr", err_addr_o, 34'h2000);

        // Sticky record, then clear coincident with a new deny
        do_req(1'b1, 34'h3000, 3'b010, 14'd7, 63'd1, 0, 0, cyc, r);
        check("sticky_rcd", err_rcd_o, 32'h0000_0005);
        check("sticky_addr", err_addr_o, 34'h2000);
        check("sticky_ovf", err_ovf_o, 1'b1);
        do_req(1'b1, 34'h4000, 3'b001, 14'd9, 63'd1, 33, 0, cyc, r);
        check("clr_deny_valid", err_valid_o, 1'b1);
        check("clr_deny_ovf", err_ovf_o, 1'b0);
        check("clr_deny_rcd", err_rcd_o, 32'h0000_4009);
        check("clr_deny_addr", err_addr_o, 34'h4000);

        // Reset while walking entry 4
        @(negedge clk_i);
        enable_i     = 1'b1;
        req_valid_i  = 1'b1;
        req_addr_i   = 34'h5000;
        req_access_i = 3'b001;
        req_sid_i    = 14'd11;
        req_md_i     = 63'd1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midwalk_rst_ready", req_ready_o, 1'b1);
        check("midwalk_rst_valid", rsp_valid_o, 1'b0);
        check("midwalk_rst_err", err_valid_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready", req_ready_o, 1'b1);
        saw_rsp = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (rsp_valid_o) saw_rsp = 1'b1;
        end
        check("post_rst_no_rsp", saw_rsp, 1'b0);
        check("post_rst_err_valid", err_valid_o, 1'b0);

        // Randomized traffic; the cycle compare process does the checking
        for (int n = 0; n < 200; n++) begin
            logic [PLEN-1:0] ra;
            int              clr;
            if (n % 8 == 0) random_entries();
            if ($urandom_range(0, 9) == 0) ra = PLEN'({$urandom, 2'b00});
            else ra = PLEN'($urandom_range(0, 130)) << 2;
            clr = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 34) : 0;
            do_req(($urandom_range(0, 9) != 0), ra, 3'($urandom_range(0, 3)), 14'($urandom),
                   63'($urandom_range(0, 15)), clr, $urandom_range(0, 3), cyc, r);
        end

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
